// File: rtl/mem_store_buffer_if.sv
// Store-buffer bus: pipeline store handshake on one side, data-memory write
// port on the other, plus buffer status.
interface mem_store_buffer_if #(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
);
   logic             st_valid_i;
   logic             st_ready_o;
   logic [31:0]      st_addr_i;
   logic [31:0]      st_data_i;
   logic [1:0]       st_size_i;
   logic             mem_we_o;
   logic [31:0]      mem_addr_o;
   logic [31:0]      mem_wdata_o;
   logic [3:0]       mem_wstrb_o;
   logic             mem_ack_i;
   logic             misalign_o;
   logic             empty_o;
   logic [CNT_W-1:0] count_o;

   modport master (
      output st_valid_i, st_addr_i, st_data_i, st_size_i, mem_ack_i,
      input  st_ready_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
             misalign_o, empty_o, count_o
   );

   modport slave (
      input  st_valid_i, st_addr_i, st_data_i, st_size_i, mem_ack_i,
      output st_ready_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
             misalign_o, empty_o, count_o
   );
endinterface

// File: rtl/mem_store_buffer.sv
// MEM-stage store buffer: aligns and lane-formats stores, queues them in a
// circular FIFO and drains them to data memory over a valid/ack handshake.
module mem_store_buffer #(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input logic               clk_i,
   input logic               rst_i,
   mem_store_buffer_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);

   typedef struct packed {
      logic [29:0] waddr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } entry_t;

   entry_t           entry_q [DEPTH];
   entry_t           entry_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             misalign_q, misalign_d;

   logic             full, empty, push, enq, pop, misaligned;
   logic [1:0]       a;
   entry_t           new_entry;
   entry_t           head;

   always_comb begin
      a               = bus.st_addr_i[1:0];
      misaligned      = 1'b0;
      new_entry       = '0;
      new_entry.waddr = bus.st_addr_i[31:2];
      case (bus.st_size_i)
         2'b00: begin
            new_entry.wdata = {4{bus.st_data_i[7:0]}};
            new_entry.wstrb = 4'b0001 << a;
         end
         2'b01: begin
            misaligned      = a[0];
            new_entry.wdata = {2{bus.st_data_i[15:0]}};
            new_entry.wstrb = 4'b0011 << {a[1], 1'b0};
         end
         2'b10: begin
            misaligned      = (a != 2'b00);
            new_entry.wdata = bus.st_data_i;
            new_entry.wstrb = 4'b1111;
         end
         default: misaligned = 1'b1;
      endcase
   end

   // Handshake qualifiers depend only on registered count, so ready/valid
   // never combinationally follow st_valid_i or mem_ack_i.
   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign push  = bus.st_valid_i && !full;
   assign enq   = push && !misaligned;
   assign pop   = !empty && bus.mem_ack_i;

   always_comb begin
      entry_d = entry_q;
      if (enq) entry_d[wr_ptr_q] = new_entry;
      wr_ptr_d   = wr_ptr_q + PTR_W'(enq);
      rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
      count_d    = count_q + CNT_W'(enq) - CNT_W'(pop);
      misalign_d = push && misaligned;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         misalign_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         misalign_q <= misalign_d;
      end
   end

   // Payload array needs no reset; outputs are masked while empty instead.
   always_ff @(posedge clk_i) begin
      entry_q <= entry_d;
   end

   assign head            = entry_q[rd_ptr_q];
   assign bus.st_ready_o  = !full;
   assign bus.mem_we_o    = !empty;
   assign bus.mem_addr_o  = empty ? 32'h0 : {head.waddr, 2'b00};
   assign bus.mem_wdata_o = empty ? 32'h0 : head.wdata;
   assign bus.mem_wstrb_o = empty ? 4'h0  : head.wstrb;
   assign bus.misalign_o  = misalign_q;
   assign bus.empty_o     = empty;
   assign bus.count_o     = count_q;
endmodule
